// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter granting exclusive ownership of one shared storage register.
// Ownership ends when the owner drops req or after MAX_HOLD cycles, with a timeout pulse on forced revoke.
module reg_share_arbiter #(
    parameter int N_REQ    = 4,
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       we,
    input  logic [N_REQ*WIDTH-1:0] wdata,
    output logic [N_REQ-1:0]       gnt,
    output logic [1:0]             owner_id,
    output logic                   busy,
    output logic [WIDTH-1:0]       q,
    output logic                   timeout
);

    localparam logic [0:0] STATE_IDLE  = 1'b0;
    localparam logic [0:0] STATE_GRANT = 1'b1;
    localparam logic [7:0] MAX_HOLD_C  = 8'(MAX_HOLD);

    logic [0:0]       state_q, state_d;
    logic [1:0]       owner_q, owner_d;
    logic [1:0]       rr_ptr_q, rr_ptr_d;
    logic [7:0]       hold_cnt_q, hold_cnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             timeout_q, timeout_d;

    logic             pick_found;
    logic [1:0]       pick_idx;
    logic [1:0]       scan_idx;
    logic [WIDTH-1:0] owner_wdata;

    // Upward search from rr_ptr, wrapping 3 -> 0; the first requester seen wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = rr_ptr_q;
        scan_idx   = rr_ptr_q;
        for (int i = 0; i < N_REQ; i++) begin
            scan_idx = rr_ptr_q + 2'(i);
            if (!pick_found && req[scan_idx]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        owner_wdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (owner_q == 2'(i)) begin
                owner_wdata = wdata[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        hold_cnt_d = hold_cnt_q;
        q_d        = q_q;
        timeout_d  = 1'b0;
        case (state_q)
            STATE_IDLE: begin
                if (pick_found) begin
                    state_d    = STATE_GRANT;
                    owner_d    = pick_idx;
                    hold_cnt_d = 8'd1;
                end
            end
            STATE_GRANT: begin
                // The owner's write lands even on the edge that ends its ownership.
                if (we[owner_q]) begin
                    q_d = owner_wdata;
                end
                if (!req[owner_q] || (hold_cnt_q == MAX_HOLD_C)) begin
                    state_d    = STATE_IDLE;
                    owner_d    = 2'd0;
                    rr_ptr_d   = owner_q + 2'd1;
                    hold_cnt_d = 8'd0;
                    timeout_d  = req[owner_q];
                end else if (hold_cnt_q < MAX_HOLD_C) begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d    = STATE_IDLE;
                owner_d    = 2'd0;
                hold_cnt_d = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= STATE_IDLE;
            owner_q    <= 2'd0;
            rr_ptr_q   <= 2'd0;
            hold_cnt_q <= 8'd0;
            q_q        <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            hold_cnt_q <= hold_cnt_d;
            q_q        <= q_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        busy     = (state_q == STATE_GRANT);
        owner_id = busy ? owner_q : 2'd0;
        q        = q_q;
        timeout  = timeout_q;
        for (int i = 0; i < N_REQ; i++) begin
            gnt[i] = busy && (owner_q == 2'(i));
        end
    end

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Drives two arbiters (MAX_HOLD=3 and MAX_HOLD=1) with shared inputs and checks both against
// an ownership-level reference model.
module tb_reg_share_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  we;
    logic [31:0] wdata;

    logic [3:0]  gnt_a, gnt_b;
    logic [1:0]  owner_a, owner_b;
    logic        busy_a, busy_b;
    logic [7:0]  q_a, q_b;
    logic        timeout_a, timeout_b;

    int n_vec = 0;
    int n_err = 0;

    int          m_owner [2];
    int          m_ptr   [2];
    int          m_held  [2];
    logic [7:0]  m_q     [2];
    logic        m_to    [2];
    int          m_max   [2] = '{3, 1};

    reg_share_arbiter #(.N_REQ(4), .WIDTH(8), .MAX_HOLD(3)) dut_a (
        .clk(clk), .rst(rst), .req(req), .we(we), .wdata(wdata),
        .gnt(gnt_a), .owner_id(owner_a), .busy(busy_a), .q(q_a), .timeout(timeout_a)
    );

    reg_share_arbiter #(.N_REQ(4), .WIDTH(8), .MAX_HOLD(1)) dut_b (
        .clk(clk), .rst(rst), .req(req), .we(we), .wdata(wdata),
        .gnt(gnt_b), .owner_id(owner_b), .busy(busy_b), .q(q_b), .timeout(timeout_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            m_owner[k] = -1;
            m_ptr[k]   = 0;
            m_held[k]  = 0;
            m_q[k]     = 8'h00;
            m_to[k]    = 1'b0;
        end
    endtask

    // One clock edge of the ownership rules, using the inputs as sampled at that edge.
    task automatic modelStep();
        int o;
        if (!rst) begin
            modelReset();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            o = m_owner[k];
            m_to[k] = 1'b0;
            if (o < 0) begin
                for (int s = 0; s < 4; s++) begin
                    if (m_owner[k] < 0 && req[(m_ptr[k] + s) % 4]) begin
                        m_owner[k] = (m_ptr[k] + s) % 4;
                        m_held[k]  = 1;
                    end
                end
            end else begin
                if (we[o]) m_q[k] = wdata[o*8 +: 8];
                if (!req[o] || m_held[k] == m_max[k]) begin
                    m_to[k]    = req[o];
                    m_ptr[k]   = (o + 1) % 4;
                    m_owner[k] = -1;
                    m_held[k]  = 0;
                end else begin
                    m_held[k] = m_held[k] + 1;
                end
            end
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag);
        logic [3:0] eg [2];
        for (int k = 0; k < 2; k++) eg[k] = (m_owner[k] >= 0) ? (4'b0001 << m_owner[k]) : 4'b0000;
        checkOutput({tag, ".a.gnt"},     32'(gnt_a),     32'(eg[0]));
        checkOutput({tag, ".a.owner"},   32'(owner_a),   (m_owner[0] >= 0) ? m_owner[0] : 0);
        checkOutput({tag, ".a.busy"},    32'(busy_a),    32'(m_owner[0] >= 0));
        checkOutput({tag, ".a.q"},       32'(q_a),       32'(m_q[0]));
        checkOutput({tag, ".a.timeout"}, 32'(timeout_a), 32'(m_to[0]));
        checkOutput({tag, ".b.gnt"},     32'(gnt_b),     32'(eg[1]));
        checkOutput({tag, ".b.owner"},   32'(owner_b),   (m_owner[1] >= 0) ? m_owner[1] : 0);
        checkOutput({tag, ".b.busy"},    32'(busy_b),    32'(m_owner[1] >= 0));
        checkOutput({tag, ".b.q"},       32'(q_b),       32'(m_q[1]));
        checkOutput({tag, ".b.timeout"}, 32'(timeout_b), 32'(m_to[1]));
    endtask

    task automatic applyStimulus(input string tag, input logic [3:0] r, input logic [3:0] w,
                                 input logic [31:0] d);
        req   = r;
        we    = w;
        wdata = d;
        @(posedge clk);
        modelStep();
        #1;
        checkAll(tag);
    endtask

    // Asserts reset between edges, checks the asynchronous effect, holds one edge, releases.
    task automatic resetPulse(input string tag);
        #2 rst = 1'b0;
        modelReset();
        #1 checkAll({tag, ".async"});
        @(posedge clk);
        modelStep();
        #1 checkAll({tag, ".held"});
        #2 rst = 1'b1;
    endtask

    initial begin
        rst   = 1'b0;
        req   = 4'b0;
        we    = 4'b0;
        wdata = 32'h0;
        modelReset();
        #3 checkAll("por");
        @(posedge clk);
        #1;
        resetPulse("init");

        // Single requester writes A5
        applyStimulus("w0.grant", 4'b0001, 4'b0001, 32'h0000_00A5);
        checkOutput("w0.gnt_latency", 32'(gnt_a), 32'h1);
        checkOutput("w0.q_before", 32'(q_a), 32'h0);
        applyStimulus("w0.write", 4'b0001, 4'b0001, 32'h0000_00A5);
        checkOutput("w0.q_after", 32'(q_a), 32'hA5);
        checkOutput("w0.busy", 32'(busy_a), 32'h1);

        // All requesting: rotation with timeouts
        resetPulse("rot");
        for (int c = 0; c < 22; c++) applyStimulus("rot", 4'b1111, 4'b0000, 32'h0);

        // Non-owner write ignored
        resetPulse("nonown");
        applyStimulus("nonown.grant", 4'b0100, 4'b0000, 32'h0);
        applyStimulus("nonown.we1", 4'b0100, 4'b0010, 32'h0000_3C00);
        checkOutput("nonown.q", 32'(q_a), 32'h0);
        checkOutput("nonown.gnt", 32'(gnt_a), 32'h4);

        // Voluntary release then wrap-around search
        resetPulse("drop");
        applyStimulus("drop.c1", 4'b0010, 4'b0000, 32'h0);
        applyStimulus("drop.c2", 4'b0010, 4'b0000, 32'h0);
        applyStimulus("drop.rel", 4'b0000, 4'b0000, 32'h0);
        checkOutput("drop.gnt", 32'(gnt_a), 32'h0);
        checkOutput("drop.timeout", 32'(timeout_a), 32'h0);
        applyStimulus("drop.next", 4'b0011, 4'b0000, 32'h0);
        checkOutput("drop.wrap", 32'(gnt_a), 32'h1);

        // Reset mid-grant
        resetPulse("mid");
        applyStimulus("mid.grant", 4'b1000, 4'b1000, 32'h7700_0000);
        applyStimulus("mid.write", 4'b1000, 4'b1000, 32'h7700_0000);
        checkOutput("mid.q_written", 32'(q_a), 32'h77);
        resetPulse("mid.rst");
        checkOutput("mid.q_cleared", 32'(q_a), 32'h0);
        applyStimulus("mid.regrant", 4'b1000, 4'b0000, 32'h0);
        checkOutput("mid.gnt", 32'(gnt_a), 32'h8);

        // MAX_HOLD=1 pulsing on instance b
        resetPulse("mh1");
        applyStimulus("mh1.on", 4'b0001, 4'b0000, 32'h0);
        checkOutput("mh1.on_gnt", 32'(gnt_b), 32'h1);
        applyStimulus("mh1.off", 4'b0001, 4'b0000, 32'h0);
        checkOutput("mh1.off_gnt", 32'(gnt_b), 32'h0);
        checkOutput("mh1.off_to", 32'(timeout_b), 32'h1);
        applyStimulus("mh1.on2", 4'b0001, 4'b0000, 32'h0);
        checkOutput("mh1.on2_to", 32'(timeout_b), 32'h0);
        for (int c = 0; c < 6; c++) applyStimulus("mh1", 4'b0001, 4'b0000, 32'h0);

        // Randomized traffic with sticky requests and occasional resets
        resetPulse("rnd");
        for (int c = 0; c < 600; c++) begin
            logic [3:0] r;
            r = req;
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(3) == 0) r[b] = ~r[b];
            end
            if ($urandom_range(99) == 0) resetPulse("rnd.rst");
            applyStimulus("rnd", r, 4'($urandom), $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
